stream_lane_serializer: RTL and testbench

Single-clock stream serializer that accepts one wide word of `NumLanes` lanes plus a per-lane valid mask and emits only the masked-in lanes, one per cycle, in ascending lane order. It sits in the destination clock domain directly downstream of the isochronous spill register. It converts wide words that crossed the clock boundary into a narrow lane stream for the consuming unit, with no bubble between consecutive words.

---
 rtl/stream_lane_serializer_pkg.sv | 6 +
 rtl/stream_lane_serializer_lzc.sv | 14 +
 rtl/stream_lane_serializer.sv | 51 +++++
 tb/tb_stream_lane_serializer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/stream_lane_serializer_pkg.sv
// stream_lane_serializer_pkg: shared helpers for the lane serializer
package stream_lane_serializer_pkg;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_lane_serializer_lzc.sv
// stream_lane_serializer_lzc: index of the lowest set bit, zero when empty
module stream_lane_serializer_lzc import stream_lane_serializer_pkg::*; #(
  parameter int Width = 4,
  parameter int IdxW  = idx_w(Width)
) (
  input  logic [Width-1:0] in_i,
  output logic [IdxW-1:0]  idx_o
);
  // scan from the top so the lowest set bit wins
  always_comb begin
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) idx_o = in_i[i] ? i[IdxW-1:0] : idx_o;
  end
endmodule

// File: rtl/stream_lane_serializer.sv
// stream_lane_serializer: emits the masked-in lanes of a wide word one per cycle
module stream_lane_serializer import stream_lane_serializer_pkg::*; #(
  parameter type T        = logic,
  parameter int  NumLanes = 4,
  parameter int  LaneIdxW = idx_w(NumLanes)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  T [NumLanes-1:0]     in_data_i,
  input  logic [NumLanes-1:0] in_mask_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output T                    out_data_o,
  output logic [LaneIdxW-1:0] out_lane_o,
  output logic                out_last_o
);
  if (NumLanes < 1) begin : g_bad
    $error("NumLanes must be at least 1");
  end
  T [NumLanes-1:0]     data_q;
  logic [NumLanes-1:0] pend_q, rest;
  logic [LaneIdxW-1:0] idx;
  logic                fire, accept;
  stream_lane_serializer_lzc #(.Width(NumLanes), .IdxW(LaneIdxW)) u_lzc (
    .in_i (pend_q),
    .idx_o(idx)
  );
  // beat selection and handshake; a new word may load as the last beat retires
  always_comb begin
    rest        = pend_q & ~(NumLanes'(1) << idx);
    out_valid_o = |pend_q;
    out_data_o  = data_q[idx];
    out_lane_o  = idx;
    out_last_o  = out_valid_o && rest == '0;
    fire        = out_valid_o & out_ready_i;
    in_ready_o  = ~out_valid_o | (fire & out_last_o);
    accept      = in_valid_i & in_ready_o;
  end
  // pending-lane mask: load wins over retiring the current beat
  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else if (accept) pend_q <= in_mask_i;
    else if (fire) pend_q <= rest;
  end
  // held word, deliberately without reset
  always_ff @(posedge clk_i) begin
    if (accept) data_q <= in_data_i;
  end
endmodule

// File: tb/tb_stream_lane_serializer.sv
// tb_stream_lane_serializer: vector table, corner sequences and queue-model random test
module tb_stream_lane_serializer;
  typedef logic [7:0] byte_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    int          n;
    logic [7:0]  lanes;
  } vec_t;
  typedef struct {
    logic [1:0] lane;
    byte_t      data;
  } beat_t;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0, out_last;
  logic [31:0] in_data = 0;
  logic [3:0]  in_mask = 0;
  byte_t       out_data;
  logic [1:0]  out_lane;
  int          n_chk = 0, n_fail = 0;
  vec_t        vt[8];
  beat_t       q[$];
  stream_lane_serializer #(.T(byte_t), .NumLanes(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_mask_i(in_mask), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_lane_o(out_lane),
    .out_last_o(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic beat(logic [1:0] lane, byte_t d, logic last);
    chk("beat_valid", 32'(out_valid), 1);
    chk("beat_lane", 32'(out_lane), 32'(lane));
    chk("beat_data", 32'(out_data), 32'(d));
    chk("beat_last", 32'(out_last), 32'(last));
    @(negedge clk);
  endtask
  task automatic load(logic [31:0] d, logic [3:0] m);
    @(negedge clk);
    in_valid = 1; in_data = d; in_mask = m; out_ready = 1;
    chk("load_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_lane", 32'(out_lane), 0);
  endtask
  initial begin
    vt[0] = '{32'h44332211, 4'b1111, 4, 8'he4};
    vt[1] = '{32'hd4c3b2a1, 4'b1010, 2, 8'h0d};
    vt[2] = '{32'h01020304, 4'b0000, 0, 8'h00};
    vt[3] = '{32'h5a6b7c8d, 4'b0001, 1, 8'h00};
    vt[4] = '{32'h0f1e2d3c, 4'b0100, 1, 8'h02};
    vt[5] = '{32'h99887766, 4'b1001, 2, 8'h0c};
    vt[6] = '{32'hcafef00d, 4'b1000, 1, 8'h03};
    vt[7] = '{32'h13579bdf, 4'b0110, 2, 8'h09};
    repeat (2) @(negedge clk);
    do_reset();
    foreach (vt[i]) begin
      load(vt[i].data, vt[i].mask);
      for (int b = 0; b < vt[i].n; b++) begin
        logic [1:0] l;
        l = vt[i].lanes[2*b +: 2];
        beat(l, vt[i].data[8*l +: 8], b == vt[i].n - 1);
      end
      chk("tbl_idle_valid", 32'(out_valid), 0);
      chk("tbl_idle_ready", 32'(in_ready), 1);
    end
    load(32'hddccbbaa, 4'b1111);
    in_valid = 1; in_data = 32'h00002211; in_mask = 4'b0011;
    chk("b2b_ready_busy", 32'(in_ready), 0);
    beat(0, 8'haa, 0);
    beat(1, 8'hbb, 0);
    beat(2, 8'hcc, 0);
    chk("b2b_ready_last", 32'(in_ready), 1);
    beat(3, 8'hdd, 1);
    in_valid = 0;
    beat(0, 8'h11, 0);
    beat(1, 8'h22, 1);
    chk("b2b_idle", 32'(out_valid), 0);
    load(32'h88776655, 4'b1111);
    beat(0, 8'h55, 0);
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_lane", 32'(out_lane), 1);
      chk("stall_data", 32'(out_data), 32'h66);
      chk("stall_last", 32'(out_last), 0);
      @(negedge clk);
    end
    out_ready = 1;
    beat(1, 8'h66, 0);
    beat(2, 8'h77, 0);
    beat(3, 8'h88, 1);
    load(32'h44332211, 4'b1111);
    chk("mid_lane0", 32'(out_lane), 0);
    @(negedge clk);
    chk("mid_lane1", 32'(out_lane), 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    load(32'h00ee0000, 4'b0100);
    beat(2, 8'hee, 1);
    chk("midrst_done", 32'(out_valid), 0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(1);
      out_ready = $urandom_range(1);
      in_data = $urandom;
      in_mask = 4'($urandom);
      #1;
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_ready", 32'(in_ready), 32'(q.size() == 0 || (q.size() == 1 && out_ready)));
      if (q.size() != 0) begin
        chk("rnd_lane", 32'(out_lane), 32'(q[0].lane));
        chk("rnd_data", 32'(out_data), 32'(q[0].data));
        chk("rnd_last", 32'(out_last), 32'(q.size() == 1));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && q.size() == 0)
        for (int k = 0; k < 4; k++)
          if (in_mask[k]) q.push_back('{2'(k), in_data[8*k +: 8]});
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 8 && q.size() != 0; c++) begin
      #1;
      chk("drain_lane", 32'(out_lane), 32'(q[0].lane));
      void'(q.pop_front());
      @(negedge clk);
    end
    chk("drain_empty", 32'(out_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
